mock_cu_multi: RTL and testbench
================================

# mock_cu_multi

Parametrised mock control unit for parallel-channel bench and FPGA test builds. Sits behind a `tee` on its internal bus/tag side and answers for `NUM_DEVICES` consecutive device addresses. Adds per-device busy, short-busy response, SENSE with per-device command-reject, TEST I/O, `suppress_out` flow control and bus-out parity checking. Counts transferred bytes per operation.

## Interface
- `BASE_ADDRESS`, 8'h10, first device address; devices occupy `BASE_ADDRESS` .. `BASE_ADDRESS+NUM_DEVICES-1`, no wrap past 8'hff.
- `NUM_DEVICES`, 4, device count, 1..16.
- `ENABLE_SHORT_BUSY`, 1, when 1 a busy device answers selection with the short-busy sequence.
- Ports: reset reset, synchronous, active-high; clock clk.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `bus_out` in 8, `bus_out_parity` in 1: channel bus out, odd parity.
- `operational_out`, `address_out`, `command_out`, `service_out`, `suppress_out`, `selection_x` in 1: outbound tags / select chain in.
- `bus_in` out 8, `bus_in_parity` out 1: bus in, parity = ~^`bus_in`.
- `operational_in`, `address_in`, `status_in`, `service_in`, `request_in`, `selection_y` out 1: inbound tags / select chain out.
- `mock_busy` in NUM_DEVICES: per-device busy.
- `mock_limit` in 16: byte count per READ/WRITE, sampled at DECODE.
- `command` out 8: last accepted command byte.
- `device` out 4: index of last selected device.
- `count` out 16: bytes transferred in current/last operation.
- `parity_error` out 1: sticky, set on bad `bus_out` parity; cleared only by reset.

## Operation
- Status encodings: CE+DE 8'h30, BUSY 8'h08, CE+DE+UC 8'h70, short busy (BUSY+SM) 8'h0A, zero 8'h00.
- States: IDLE, SEL, ADDR, CMDW, DECODE, ISTAT, ISTATW, RD, RDW, WR, WRW, STOPW, FSTAT, SBUSY.
- IDLE: `operational_in`=0, `selection_y`<=`selection_x`. On `address_out`&&`selection_x`&& `bus_out` in range: `selection_y`<=0, `device`<=`bus_out`-`BASE_ADDRESS`; go SBUSY if `mock_busy[dev]`&&`ENABLE_SHORT_BUSY`, else SEL.
- SEL: `operational_in`=1 until `address_out` falls -> ADDR.
- ADDR: `bus_in`=selected address, `address_in`=1; on `command_out`: latch `command`, drop `address_in` -> CMDW; wait `!command_out` -> DECODE.
- DECODE (priority): busy -> 8'h08; 8'h00 TEST I/O -> 8'h00; 8'h01 WRITE, 8'h02 READ -> 8'h00; 8'h03 NOP -> 8'h30; 8'h04 SENSE -> 8'h00; else 8'h70 and set `sense_rej[dev]`. -> ISTAT.
- ISTAT: `bus_in`=status, `status_in`=1; on `service_out` drop -> ISTATW. On `!service_out`: end to IDLE if BUSY, CE+DE, or TEST I/O; else `count`<=0, to RD (READ/SENSE), WR (WRITE); if `mock_limit`==0 for READ/WRITE go FSTAT with 8'h30.
- RD: while `suppress_out`=1 hold `service_in`=0. Else `service_in`=1, `bus_in` = `count[7:0]+1` (SENSE: {7'b0,`sense_rej[dev]`}). `command_out` (STOP) -> drop, STOPW. `service_out` -> count+1, drop, RDW. RDW on `!service_out`: done (count==limit, or SENSE after 1 byte, clearing `sense_rej[dev]`) -> FSTAT 8'h30, else RD.
- WR: same tags as RD; on `service_out` check parity, count+1 -> WRW; same exit rules.
- STOPW: wait `!command_out` -> FSTAT 8'h30.
- FSTAT: `status_in`=1 with status; on `service_out` drop -> IDLE.
- SBUSY: `operational_in`=1, `bus_in`=8'h0A, `status_in`=1 (no `address_in`); on `service_out` or `command_out` drop -> IDLE after `address_out` low.
- `operational_out` low anywhere: next cycle IDLE, all inbound tags 0, `selection_y`<=`selection_x`.

## Timing
- All outputs registered; each tag response one cycle after the sampled outbound tag.
- Reset: state IDLE, all tag outputs 0, `bus_in`=0, `selection_y`=0, `command`=0, `device`=0, `count`=0, `parity_error`=0, `sense_rej`=0. Reset mid-operation overrides everything same edge.
- `request_in` constant 0.
- Parity checked on cycles where `address_out`, `command_out` or (WR && `service_out`) sampled high.
- `count` 16-bit; compared equal to limit, no wrap checks beyond 16'hffff.
- Address outside range: no response, selection propagates unchanged.

## Test plan
- Select 8'h12, cmd 8'h03 -> `address_in` with bus 8'h12, status 8'h30, `device`=2, back to IDLE.
- READ on 8'h10, limit 3 -> bytes 01,02,03, `count`=3, final status 8'h30.
- WRITE limit 5, STOP after 2 bytes -> `count`=2, STOPW, final 8'h30.
- `mock_busy[1]`=1, select 8'h11, short busy on -> status 8'h0A, no `address_in`; short busy off -> initial status 8'h08.
- Cmd 8'h55 on 8'h13 -> 8'h70; SENSE -> byte 8'h01; second SENSE -> 8'h00.
- Bad parity on command byte -> `parity_error`=1; address 8'h20 -> no response, `selection_y` follows `selection_x`; drop `operational_out` mid-READ -> tags 0 next cycle.

Source files
------------

// File: rtl/mock_cu_multi_if.sv
// Channel bus/tag bundle between a channel (master) and a control unit (slave).
interface mock_cu_multi_if;
  logic [7:0] bus_out;
  logic       bus_out_parity;
  logic       operational_out;
  logic       address_out;
  logic       command_out;
  logic       service_out;
  logic       suppress_out;
  logic       selection_x;
  logic [7:0] bus_in;
  logic       bus_in_parity;
  logic       operational_in;
  logic       address_in;
  logic       status_in;
  logic       service_in;
  logic       request_in;
  logic       selection_y;

  modport master (
    output bus_out, bus_out_parity, operational_out, address_out, command_out,
           service_out, suppress_out, selection_x,
    input  bus_in, bus_in_parity, operational_in, address_in, status_in,
           service_in, request_in, selection_y
  );

  modport slave (
    input  bus_out, bus_out_parity, operational_out, address_out, command_out,
           service_out, suppress_out, selection_x,
    output bus_in, bus_in_parity, operational_in, address_in, status_in,
           service_in, request_in, selection_y
  );
endinterface

// File: rtl/mock_cu_multi.sv
// Mock multi-device control unit: answers selection for NUM_DEVICES consecutive
// addresses, runs TEST I/O / NOP / READ / WRITE / SENSE with busy and flow control.
module mock_cu_multi #(
  parameter logic [7:0]  BASE_ADDRESS      = 8'h10,
  parameter int unsigned NUM_DEVICES       = 4,
  parameter bit          ENABLE_SHORT_BUSY = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  mock_cu_multi_if.slave         bus,
  input  logic [NUM_DEVICES-1:0] mock_busy,
  input  logic [15:0]            mock_limit,
  output logic [7:0]             command,
  output logic [3:0]             device,
  output logic [15:0]            count,
  output logic                   parity_error
);

  typedef enum logic [3:0] {
    IDLE, SEL, ADDR, CMDW, DECODE, ISTAT, ISTATW,
    RD, RDW, WR, WRW, STOPW, FSTAT, SBUSY
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  bus_in_q, bus_in_d, status_q, status_d, command_d;
  logic        bus_par_q;
  logic        op_q, op_d, addr_q, addr_d, stat_q, stat_d, svc_q, svc_d, sely_q, sely_d;
  logic [3:0]  device_d, sel_idx;
  logic [15:0] count_d, limit_q, limit_d, rej_q, rej_d, busy_ext;
  logic        perr_d, checked, in_range, is_sense, is_rw, xfer_done;
  logic [8:0]  addr_ext;
  logic [7:0]  st;

  assign bus.bus_in         = bus_in_q;
  assign bus.bus_in_parity  = bus_par_q;
  assign bus.operational_in = op_q;
  assign bus.address_in     = addr_q;
  assign bus.status_in      = stat_q;
  assign bus.service_in     = svc_q;
  assign bus.selection_y    = sely_q;
  assign bus.request_in     = 1'b0;

  assign busy_ext  = 16'(mock_busy);
  assign addr_ext  = {1'b0, bus.bus_out};
  // 9-bit compare so the device window never wraps past 8'hff
  assign in_range  = (addr_ext >= {1'b0, BASE_ADDRESS}) &&
                     (addr_ext < ({1'b0, BASE_ADDRESS} + 9'(NUM_DEVICES)));
  assign sel_idx   = 4'(bus.bus_out - BASE_ADDRESS);
  assign is_sense  = (command == 8'h04);
  assign is_rw     = (command == 8'h01) || (command == 8'h02);
  assign checked   = bus.address_out || bus.command_out || ((state_q == WR) && bus.service_out);
  assign xfer_done = ((state_q == RDW) && is_sense) || (count == limit_q);

  always_comb begin
    state_d   = state_q;
    bus_in_d  = bus_in_q;
    op_d      = op_q;
    addr_d    = addr_q;
    stat_d    = stat_q;
    svc_d     = svc_q;
    sely_d    = sely_q;
    command_d = command;
    device_d  = device;
    count_d   = count;
    status_d  = status_q;
    limit_d   = limit_q;
    rej_d     = rej_q;
    st        = 8'h00;
    perr_d    = parity_error | (checked && !(^{bus.bus_out, bus.bus_out_parity}));

    if (!bus.operational_out) begin
      state_d  = IDLE;
      bus_in_d = '0;
      op_d     = 1'b0;
      addr_d   = 1'b0;
      stat_d   = 1'b0;
      svc_d    = 1'b0;
      sely_d   = bus.selection_x;
    end else begin
      unique case (state_q)
        IDLE: begin
          op_d     = 1'b0;
          addr_d   = 1'b0;
          stat_d   = 1'b0;
          svc_d    = 1'b0;
          bus_in_d = '0;
          sely_d   = bus.selection_x;
          if (bus.address_out && bus.selection_x && in_range) begin
            sely_d   = 1'b0;
            device_d = sel_idx;
            op_d     = 1'b1;
            if (ENABLE_SHORT_BUSY && busy_ext[sel_idx]) begin
              state_d  = SBUSY;
              bus_in_d = 8'h0A;
              stat_d   = 1'b1;
            end else begin
              state_d = SEL;
            end
          end
        end
        SEL: if (!bus.address_out) begin
          state_d  = ADDR;
          addr_d   = 1'b1;
          bus_in_d = BASE_ADDRESS + {4'b0, device};
        end
        ADDR: if (bus.command_out) begin
          command_d = bus.bus_out;
          addr_d    = 1'b0;
          bus_in_d  = '0;
          state_d   = CMDW;
        end
        CMDW: if (!bus.command_out) state_d = DECODE;
        DECODE: begin
          if (busy_ext[device]) st = 8'h08;
          else if (command == 8'h03) st = 8'h30;
          else if (command <= 8'h04) st = 8'h00;
          else begin
            st            = 8'h70;
            rej_d[device] = 1'b1;
          end
          status_d = st;
          bus_in_d = st;
          stat_d   = 1'b1;
          limit_d  = mock_limit;
          state_d  = ISTAT;
        end
        ISTAT: if (bus.service_out) begin
          stat_d   = 1'b0;
          bus_in_d = '0;
          state_d  = ISTATW;
        end
        ISTATW: if (!bus.service_out) begin
          if ((status_q == 8'h00) && (is_rw || is_sense)) begin
            count_d = '0;
            if (is_rw && (limit_q == 16'h0000)) begin
              state_d  = FSTAT;
              status_d = 8'h30;
              bus_in_d = 8'h30;
              stat_d   = 1'b1;
            end else begin
              state_d = (command == 8'h01) ? WR : RD;
            end
          end else begin
            state_d = IDLE;
            op_d    = 1'b0;
          end
        end
        RD, WR: begin
          // STOP outranks a pending data handshake
          if (bus.command_out) begin
            svc_d    = 1'b0;
            bus_in_d = '0;
            state_d  = STOPW;
          end else if (bus.service_out && svc_q) begin
            svc_d   = 1'b0;
            count_d = count + 16'd1;
            state_d = (state_q == RD) ? RDW : WRW;
          end else if (bus.suppress_out) begin
            svc_d = 1'b0;
          end else begin
            svc_d = 1'b1;
            if (state_q == RD)
              bus_in_d = is_sense ? {7'b0, rej_q[device]} : (count[7:0] + 8'd1);
            else
              bus_in_d = '0;
          end
        end
        RDW, WRW: if (!bus.service_out) begin
          if (xfer_done) begin
            if (is_sense) rej_d[device] = 1'b0;
            state_d  = FSTAT;
            status_d = 8'h30;
            bus_in_d = 8'h30;
            stat_d   = 1'b1;
          end else begin
            state_d = (state_q == RDW) ? RD : WR;
          end
        end
        STOPW: if (!bus.command_out) begin
          state_d  = FSTAT;
          status_d = 8'h30;
          bus_in_d = 8'h30;
          stat_d   = 1'b1;
        end
        FSTAT: if (bus.service_out) begin
          stat_d   = 1'b0;
          op_d     = 1'b0;
          bus_in_d = '0;
          state_d  = IDLE;
        end
        SBUSY: begin
          // status_in low marks the short-busy status as already accepted
          if (stat_q && (bus.service_out || bus.command_out)) begin
            stat_d   = 1'b0;
            bus_in_d = '0;
          end else if (!stat_q && !bus.address_out) begin
            op_d    = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bus_in_q     <= '0;
      bus_par_q    <= 1'b0;
      op_q         <= 1'b0;
      addr_q       <= 1'b0;
      stat_q       <= 1'b0;
      svc_q        <= 1'b0;
      sely_q       <= 1'b0;
      command      <= '0;
      device       <= '0;
      count        <= '0;
      status_q     <= '0;
      limit_q      <= '0;
      rej_q        <= '0;
      parity_error <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_in_q     <= bus_in_d;
      bus_par_q    <= ~^bus_in_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      stat_q       <= stat_d;
      svc_q        <= svc_d;
      sely_q       <= sely_d;
      command      <= command_d;
      device       <= device_d;
      count        <= count_d;
      status_q     <= status_d;
      limit_q      <= limit_d;
      rej_q        <= rej_d;
      parity_error <= perr_d;
    end
  end

endmodule

// File: tb/tb_mock_cu_multi.sv
// Channel-side bench for mock_cu_multi: directed plan plus randomized operations
// checked against a command-level model of status, data bytes and sense state.
module tb_mock_cu_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  bus_out;
  logic        bus_out_parity, oper, address_out, command_out, service_out, suppress_out, selection_x;
  logic        use2;
  logic [3:0]  mock_busy;
  logic [15:0] mock_limit;
  logic [7:0]  command1, command2;
  logic [3:0]  device1, device2;
  logic [15:0] count1, count2;
  logic        perr1, perr2;

  int tests = 0;
  int fails = 0;
  logic model_rej [16];
  logic corrupt_cmd;

  localparam int T_OP = 0, T_ADDR = 1, T_STAT = 2, T_SVC = 3, T_SY = 4;

  mock_cu_multi_if ch1();
  mock_cu_multi_if ch2();

  assign ch1.bus_out = bus_out;             assign ch2.bus_out = bus_out;
  assign ch1.bus_out_parity = bus_out_parity; assign ch2.bus_out_parity = bus_out_parity;
  assign ch1.address_out = address_out;     assign ch2.address_out = address_out;
  assign ch1.command_out = command_out;     assign ch2.command_out = command_out;
  assign ch1.service_out = service_out;     assign ch2.service_out = service_out;
  assign ch1.suppress_out = suppress_out;   assign ch2.suppress_out = suppress_out;
  assign ch1.selection_x = selection_x;     assign ch2.selection_x = selection_x;
  assign ch1.operational_out = oper & ~use2;
  assign ch2.operational_out = oper & use2;

  mock_cu_multi dut1 (
    .clk(clk), .reset(reset), .bus(ch1), .mock_busy(mock_busy), .mock_limit(mock_limit),
    .command(command1), .device(device1), .count(count1), .parity_error(perr1)
  );

  mock_cu_multi #(.ENABLE_SHORT_BUSY(1'b0)) dut2 (
    .clk(clk), .reset(reset), .bus(ch2), .mock_busy(mock_busy), .mock_limit(mock_limit),
    .command(command2), .device(device2), .count(count2), .parity_error(perr2)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic tag_now(input int t);
    case (t)
      T_OP:    return use2 ? ch2.operational_in : ch1.operational_in;
      T_ADDR:  return use2 ? ch2.address_in : ch1.address_in;
      T_STAT:  return use2 ? ch2.status_in : ch1.status_in;
      T_SVC:   return use2 ? ch2.service_in : ch1.service_in;
      default: return use2 ? ch2.selection_y : ch1.selection_y;
    endcase
  endfunction

  function automatic logic [7:0] obs_bus();
    return use2 ? ch2.bus_in : ch1.bus_in;
  endfunction

  function automatic logic [15:0] obs_count();
    return use2 ? count2 : count1;
  endfunction

  function automatic logic [7:0] model_status(input logic busy, input logic [7:0] cmd);
    if (busy) return 8'h08;
    if (cmd == 8'h03) return 8'h30;
    if (cmd <= 8'h04) return 8'h00;
    return 8'h70;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tag(input int t, input logic val, input string tag);
    int n = 0;
    while (tag_now(t) !== val && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, tag_now(t)}, {31'b0, val});
  endtask

  task automatic put(input logic [7:0] d);
    bus_out = d;
    bus_out_parity = ~^d;
  endtask

  task automatic sel_cmd(input logic [7:0] addr, input logic [7:0] cmd, input logic [7:0] exp_st);
    put(addr);
    selection_x = 1'b1;
    address_out = 1'b1;
    wait_tag(T_OP, 1'b1, "op_in_up");
    check("sel_y_blocked", {31'b0, tag_now(T_SY)}, 0);
    address_out = 1'b0;
    selection_x = 1'b0;
    wait_tag(T_ADDR, 1'b1, "addr_in_up");
    check("addr_echo", obs_bus(), addr);
    check("device", use2 ? device2 : device1, addr - 8'h10);
    put(cmd);
    bus_out_parity = bus_out_parity ^ corrupt_cmd;
    command_out = 1'b1;
    wait_tag(T_ADDR, 1'b0, "addr_in_dn");
    command_out = 1'b0;
    put(8'h00);
    wait_tag(T_STAT, 1'b1, "istat_up");
    check("init_status", obs_bus(), exp_st);
    service_out = 1'b1;
    wait_tag(T_STAT, 1'b0, "istat_dn");
    service_out = 1'b0;
  endtask

  task automatic end_status(input logic [7:0] exp_st);
    wait_tag(T_STAT, 1'b1, "fstat_up");
    check("final_status", obs_bus(), exp_st);
    service_out = 1'b1;
    wait_tag(T_STAT, 1'b0, "fstat_dn");
    service_out = 1'b0;
    wait_tag(T_OP, 1'b0, "op_in_dn");
  endtask

  task automatic xfer(input bit wr, input int n, input int stop_at, input bit sense,
                      input logic [7:0] sense_byte);
    for (int i = 0; i < n; i++) begin
      wait_tag(T_SVC, 1'b1, "svc_up");
      if (i == stop_at) begin
        command_out = 1'b1;
        wait_tag(T_SVC, 1'b0, "svc_stop");
        @(negedge clk);
        command_out = 1'b0;
        return;
      end
      if (!wr) begin
        check("rd_byte", obs_bus(), sense ? sense_byte : 8'(i + 1));
        check("bi_parity", use2 ? ch2.bus_in_parity : ch1.bus_in_parity, ~^obs_bus());
      end else begin
        put(8'($urandom));
      end
      service_out = 1'b1;
      wait_tag(T_SVC, 1'b0, "svc_dn");
      service_out = 1'b0;
      put(8'h00);
    end
  endtask

  initial begin
    logic [7:0] addr, cmd, st;
    int dev, lim;
    reset = 1'b1; oper = 1'b0; use2 = 1'b0; corrupt_cmd = 1'b0;
    address_out = 0; command_out = 0; service_out = 0; suppress_out = 0; selection_x = 0;
    put(8'h00); mock_busy = '0; mock_limit = '0;
    for (int i = 0; i < 16; i++) model_rej[i] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_op_in", ch1.operational_in, 0);
    check("rst_tags", {ch1.address_in, ch1.status_in, ch1.service_in, ch1.request_in}, 0);
    check("rst_bus_sel", {ch1.bus_in, ch1.selection_y}, 0);
    check("rst_regs", {command1, device1, count1, perr1}, 0);
    reset = 1'b0;
    oper = 1'b1;
    @(negedge clk);

    // NOP on device 2
    sel_cmd(8'h12, 8'h03, 8'h30);
    wait_tag(T_OP, 1'b0, "nop_end");
    check("nop_cmd", command1, 8'h03);

    // READ of 3 bytes
    mock_limit = 16'd3;
    sel_cmd(8'h10, 8'h02, 8'h00);
    xfer(1'b0, 3, -1, 1'b0, 8'h00);
    end_status(8'h30);
    check("rd_count", count1, 16'd3);

    // WRITE stopped after 2 bytes
    mock_limit = 16'd5;
    sel_cmd(8'h11, 8'h01, 8'h00);
    xfer(1'b1, 5, 2, 1'b0, 8'h00);
    end_status(8'h30);
    check("wr_stop_count", count1, 16'd2);

    // short busy on device 1
    mock_busy = 4'b0010;
    put(8'h11); selection_x = 1'b1; address_out = 1'b1;
    wait_tag(T_OP, 1'b1, "sb_op_up");
    check("sb_status", {ch1.status_in, ch1.address_in, ch1.bus_in}, {2'b10, 8'h0A});
    service_out = 1'b1;
    wait_tag(T_STAT, 1'b0, "sb_stat_dn");
    service_out = 1'b0; address_out = 1'b0; selection_x = 1'b0;
    wait_tag(T_OP, 1'b0, "sb_op_dn");

    // same device on the instance without short busy
    use2 = 1'b1;
    @(negedge clk);
    sel_cmd(8'h11, 8'h02, 8'h08);
    wait_tag(T_OP, 1'b0, "busy_end");
    use2 = 1'b0; mock_busy = '0;
    @(negedge clk);

    // command reject, then two SENSEs
    sel_cmd(8'h13, 8'h55, 8'h70);
    wait_tag(T_OP, 1'b0, "rej_end");
    model_rej[3] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sel_cmd(8'h13, 8'h04, 8'h00);
      xfer(1'b0, 1, -1, 1'b1, {7'b0, model_rej[3]});
      model_rej[3] = 1'b0;
      end_status(8'h30);
    end
    check("perr_clean", perr1, 0);

    // bad parity on the command byte
    corrupt_cmd = 1'b1;
    sel_cmd(8'h10, 8'h03, 8'h30);
    corrupt_cmd = 1'b0;
    wait_tag(T_OP, 1'b0, "par_end");
    check("perr_set", perr1, 1);

    // addresses just outside the window are ignored
    for (int k = 0; k < 3; k++) begin
      addr = (k == 0) ? 8'h0F : (k == 1) ? 8'h14 : 8'h20;
      put(addr); selection_x = 1'b1; address_out = 1'b1;
      repeat (4) @(negedge clk);
      check("oor_pass", {ch1.operational_in, ch1.selection_y}, 2'b01);
      selection_x = 1'b0;
      repeat (2) @(negedge clk);
      check("oor_follow", ch1.selection_y, 0);
      address_out = 1'b0;
    end

    // suppress_out holds off data
    mock_limit = 16'd2;
    suppress_out = 1'b1;
    sel_cmd(8'h10, 8'h02, 8'h00);
    repeat (5) @(negedge clk);
    check("suppress_hold", ch1.service_in, 0);
    suppress_out = 1'b0;
    xfer(1'b0, 2, -1, 1'b0, 8'h00);
    end_status(8'h30);

    // operational_out dropped mid-READ
    mock_limit = 16'd4;
    sel_cmd(8'h12, 8'h02, 8'h00);
    wait_tag(T_SVC, 1'b1, "drop_svc_up");
    oper = 1'b0;
    @(negedge clk);
    check("drop_tags", {ch1.operational_in, ch1.service_in, ch1.status_in, ch1.address_in}, 0);
    oper = 1'b1;
    @(negedge clk);

    // randomized operations against the command-level model
    for (int r = 0; r < 10; r++) begin
      dev = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0: cmd = 8'h00; 1: cmd = 8'h01; 2: cmd = 8'h02;
        3: cmd = 8'h03; 4: cmd = 8'h04; default: cmd = 8'($urandom_range(5, 255));
      endcase
      lim = $urandom_range(0, 4);
      mock_limit = 16'(lim);
      st = model_status(1'b0, cmd);
      sel_cmd(8'h10 + 8'(dev), cmd, st);
      if ((cmd == 8'h01 || cmd == 8'h02) && lim == 0) begin
        end_status(8'h30);
        check("rnd_zero_count", count1, 0);
      end else if (cmd == 8'h01 || cmd == 8'h02) begin
        xfer(cmd == 8'h01, lim, -1, 1'b0, 8'h00);
        end_status(8'h30);
        check("rnd_count", count1, 16'(lim));
      end else if (cmd == 8'h04) begin
        xfer(1'b0, 1, -1, 1'b1, {7'b0, model_rej[dev]});
        model_rej[dev] = 1'b0;
        end_status(8'h30);
      end else begin
        if (st == 8'h70) model_rej[dev] = 1'b1;
        wait_tag(T_OP, 1'b0, "rnd_end");
      end
      check("rnd_cmd", obs_count() === obs_count() ? command1 : 8'hxx, cmd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
